wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Registered, flow-controlled write-back stage for the core pipeline. It replaces the combinational mem-to-wb pass-through.
- Accepts one retiring instruction per cycle from MEM over a valid/ready handshake.
- Performs load-data lane extraction and sign/zero extension, and suppresses writes to x0.
- Presents the result to the register-file write port through a 2-entry skid buffer, so back-pressure from the write port (CSR/regfile arbitration) does not create a combinational ready path into MEM.

Parameters:
- XLEN, 32, data width; legal values 32 or 64.
- REG_AW, 5, register address width.
- PC_W, 32, program-counter width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; asynchronous, active-low
- wb_flush_i  in  1  kill all buffered instructions
- wb_valid_i  in  1  MEM presents an instruction
- wb_ready_o  out  1  stage can accept
- wb_pc_i  in  PC_W  instruction PC
- wb_rd_wr_en_i  in  1  instruction writes rd
- wb_rd_addr_i  in  REG_AW  destination register
- wb_rd_reg_data_i  in  XLEN  ALU/CSR result (non-load)
- wb_is_load_i  in  1  select load path
- wb_load_funct3_i  in  3  RISC-V load funct3
- wb_load_data_i  in  XLEN  raw aligned memory word
- wb_addr_lsb_i  in  log2(XLEN/8)  byte offset of the access
- wb_valid_o  out  1  result valid
- wb_ready_i  in  1  register-file port accepts
- wb_pc_o  out  PC_W  retiring PC
- wb_rd_wr_en_o  out  1  write strobe; qualified by wb_valid_o
- wb_rd_addr_o  out  REG_AW  destination register
- wb_rd_reg_data_o  out  XLEN  final write data

Behaviour:
- Reset:
  - All outputs are 0 and both buffer entries are empty.
  - wb_ready_o is 1 from the first cycle after deassertion.
- Input transfer occurs when wb_valid_i & wb_ready_o. The output handshake completes when wb_valid_o & wb_ready_i.
- Storage: an output register (main) plus one skid entry.
  - wb_ready_o equals !skid_valid and is driven directly from a flop.
- Latency: 1 cycle from input transfer to wb_valid_o when the buffer is empty.
- Back-pressure:
  - If main is valid and not accepted, an incoming transfer goes to skid, and wb_ready_o drops the next cycle.
  - When main is accepted, skid moves to main, and wb_ready_o rises the next cycle.
- Simultaneous input and output transfer with skid empty: main reloads directly from the input. Throughput is 1 per cycle.
- Order is strictly preserved, with no bypass around skid.
- Load path (computed before the register):
  - The byte lane is selected by wb_addr_lsb_i, aligned down to the access size.
  - funct3 decoding:
    - 000 LB: sign-extend byte.
    - 001 LH: sign-extend halfword.
    - 010 LW: sign-extend word to XLEN.
    - 100 LBU: zero-extend byte.
    - 101 LHU: zero-extend halfword.
    - 011 LD and 110 LWU: legal only when XLEN=64. When XLEN=32 they are treated as LW.
    - 111: data passes unmodified.
  - When wb_is_load_i=0, wb_rd_reg_data_i passes unmodified.
- x0: the registered write enable is forced to 0 when rd_addr==0. The address and data still propagate.
- Flush:
  - At the next edge both entries are cleared, wb_valid_o=0, and wb_ready_o=1.
  - An input presented in the same cycle as flush is discarded.
  - Flush overrides a simultaneous output handshake; the port sees the transfer as completing in that cycle.
- Output data fields hold their value while wb_valid_o=1 and wb_ready_i=0 (AXI-style stability).
- Asynchronous reset assertion mid-operation clears everything immediately. Nothing is retired after it.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- When defined:
  - Add output wb_instret_o (64 bits): a free-running count of completed output handshakes.
  - Resets to 0, is not cleared by flush, and wraps at 2^64-1 to 0.
- When undefined: the port and counter do not exist.

Decomposition:
- Shared package define.v gains:
  - load funct3 constants: LB, LH, LW, LD, LBU, LHU, LWU;
  - the XLEN-derived lane-offset width macro.
- One natural sub-module: wb_load_align. It is purely combinational: funct3, lsb and raw data in; extended data out.
- The skid buffer stays inline.

Test Plan:
- XLEN=32, load 0x80FF7F01, LB at lsb=1 -> 0x0000007F. LB at lsb=2 -> 0xFFFFFFFF. LHU at lsb=2 -> 0x000080FF. LH at lsb=2 -> 0xFFFF80FF.
- Streaming 8 back-to-back instructions with wb_ready_i=1 -> 8 outputs on consecutive cycles, first output one cycle after the first input, same order, wb_ready_o constantly 1.
- Hold wb_ready_i=0 and present 3 inputs -> 2 accepted, wb_ready_o=0 from the cycle after the second. Release ready -> outputs appear in order on consecutive cycles, and wb_ready_o=1 the cycle after skid drains.
- Write to x0 with data 0xDEADBEEF -> wb_valid_o=1, wb_rd_wr_en_o=0, data 0xDEADBEEF.
- Buffer full, then assert flush together with a new valid input -> next cycle wb_valid_o=0 and wb_ready_o=1, and the flushed input never appears.
- WB_RETIRE_CNT_EN defined: 5 completed handshakes, 2 of them stalled, plus a flush of 1 buffered entry -> wb_instret_o=5. rst_n low mid-stream -> counter 0 immediately.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: RISC-V load funct3 codes and
// the XLEN-derived byte-lane offset width.
package wb_stage_pkg;

  typedef enum logic [2:0] {
    LB   = 3'b000,
    LH   = 3'b001,
    LW   = 3'b010,
    LD   = 3'b011,
    LBU  = 3'b100,
    LHU  = 3'b101,
    LWU  = 3'b110,
    LRAW = 3'b111
  } load_funct3_e;

  // Width of the byte offset inside one XLEN-wide memory word.
  function automatic int lsb_width(input int xlen);
    return $clog2(xlen / 8);
  endfunction

endpackage

// File: rtl/wb_load_align.sv
// Combinational load-data lane extraction with sign/zero extension.
// LD and LWU decode as LW when XLEN is 32; funct3 111 passes raw data through.
module wb_load_align
  import wb_stage_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int LSB_W = lsb_width(XLEN)
) (
  input  logic [2:0]       funct3,
  input  logic [LSB_W-1:0] lsb,
  input  logic [XLEN-1:0]  raw_data,
  output logic [XLEN-1:0]  load_data
);

  logic [LSB_W-1:0] offset;
  logic [XLEN-1:0]  shifted;

  always_comb begin
    offset = lsb;
    case (funct3[1:0])
      2'b01:   offset = lsb & ~LSB_W'(1);
      2'b10:   offset = lsb & ~LSB_W'(3);
      2'b11:   offset = '0;
      default: offset = lsb;
    endcase
    shifted = raw_data >> {offset, 3'b000};
  end

  always_comb begin
    load_data = raw_data;
    case (funct3)
      LB:      load_data = XLEN'(signed'(shifted[7:0]));
      LH:      load_data = XLEN'(signed'(shifted[15:0]));
      LW:      load_data = XLEN'(signed'(shifted[31:0]));
      LBU:     load_data = XLEN'(shifted[7:0]);
      LHU:     load_data = XLEN'(shifted[15:0]);
      LD:      load_data = (XLEN == 64) ? shifted : XLEN'(signed'(shifted[31:0]));
      LWU:     load_data = (XLEN == 64) ? XLEN'(shifted[31:0]) : XLEN'(signed'(shifted[31:0]));
      default: load_data = raw_data;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Registered write-back stage with a 2-entry skid buffer (main + skid).
// Optional retire counter port wb_instret_o enabled by macro WB_RETIRE_CNT_EN.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter  int XLEN   = 32,
  parameter  int REG_AW = 5,
  parameter  int PC_W   = 32,
  localparam int LSB_W  = lsb_width(XLEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_flush_i,
  input  logic              wb_valid_i,
  output logic              wb_ready_o,
  input  logic [PC_W-1:0]   wb_pc_i,
  input  logic              wb_rd_wr_en_i,
  input  logic [REG_AW-1:0] wb_rd_addr_i,
  input  logic [XLEN-1:0]   wb_rd_reg_data_i,
  input  logic              wb_is_load_i,
  input  logic [2:0]        wb_load_funct3_i,
  input  logic [XLEN-1:0]   wb_load_data_i,
  input  logic [LSB_W-1:0]  wb_addr_lsb_i,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [PC_W-1:0]   wb_pc_o,
  output logic              wb_rd_wr_en_o,
  output logic [REG_AW-1:0] wb_rd_addr_o,
`ifdef WB_RETIRE_CNT_EN
  output logic [63:0]       wb_instret_o,
`endif
  output logic [XLEN-1:0]   wb_rd_reg_data_o
);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic              wr_en;
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } entry_t;

  entry_t           in_entry, main_q, main_d, skid_q, skid_d;
  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             ready_q, ready_d;
  logic             in_fire, out_fire;
  logic [XLEN-1:0]  load_data;

  wb_load_align #(.XLEN(XLEN)) u_load_align (
    .funct3    (wb_load_funct3_i),
    .lsb       (wb_addr_lsb_i),
    .raw_data  (wb_load_data_i),
    .load_data (load_data)
  );

  always_comb begin
    in_entry.pc    = wb_pc_i;
    in_entry.wr_en = wb_rd_wr_en_i & (wb_rd_addr_i != '0);
    in_entry.addr  = wb_rd_addr_i;
    in_entry.data  = wb_is_load_i ? load_data : wb_rd_reg_data_i;
  end

  assign in_fire  = wb_valid_i & ready_q;
  assign out_fire = main_valid_q & wb_ready_i;

  // Main refills from skid first so ordering holds; the input only reaches skid while main is stalled.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (wb_flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_fire || !main_valid_q) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        main_d       = in_entry;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
    ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
    end
  end

  assign wb_ready_o       = ready_q;
  assign wb_valid_o       = main_valid_q;
  assign wb_pc_o          = main_q.pc;
  assign wb_rd_wr_en_o    = main_valid_q & main_q.wr_en;
  assign wb_rd_addr_o     = main_q.addr;
  assign wb_rd_reg_data_o = main_q.data;

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] instret_q;

  // Counts port-side handshakes, including one coinciding with a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
    end else if (out_fire) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign wb_instret_o = instret_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage (XLEN=32): table-driven load/x0 vectors
// plus directed streaming, back-pressure, flush, reset and retire-counter sequences.
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_flush_i = 1'b0;
  logic        wb_valid_i = 1'b0;
  logic        wb_ready_o;
  logic [31:0] wb_pc_i = '0;
  logic        wb_rd_wr_en_i = 1'b0;
  logic [4:0]  wb_rd_addr_i = '0;
  logic [31:0] wb_rd_reg_data_i = '0;
  logic        wb_is_load_i = 1'b0;
  logic [2:0]  wb_load_funct3_i = '0;
  logic [31:0] wb_load_data_i = '0;
  logic [1:0]  wb_addr_lsb_i = '0;
  logic        wb_valid_o;
  logic        wb_ready_i = 1'b0;
  logic [31:0] wb_pc_o;
  logic        wb_rd_wr_en_o;
  logic [4:0]  wb_rd_addr_o;
  logic [31:0] wb_rd_reg_data_o;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] wb_instret_o;
`endif

  int checks = 0;
  int errors = 0;

  wb_stage #(.XLEN(32), .REG_AW(5), .PC_W(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wb_flush_i       (wb_flush_i),
    .wb_valid_i       (wb_valid_i),
    .wb_ready_o       (wb_ready_o),
    .wb_pc_i          (wb_pc_i),
    .wb_rd_wr_en_i    (wb_rd_wr_en_i),
    .wb_rd_addr_i     (wb_rd_addr_i),
    .wb_rd_reg_data_i (wb_rd_reg_data_i),
    .wb_is_load_i     (wb_is_load_i),
    .wb_load_funct3_i (wb_load_funct3_i),
    .wb_load_data_i   (wb_load_data_i),
    .wb_addr_lsb_i    (wb_addr_lsb_i),
    .wb_valid_o       (wb_valid_o),
    .wb_ready_i       (wb_ready_i),
    .wb_pc_o          (wb_pc_o),
    .wb_rd_wr_en_o    (wb_rd_wr_en_o),
    .wb_rd_addr_o     (wb_rd_addr_o),
`ifdef WB_RETIRE_CNT_EN
    .wb_instret_o     (wb_instret_o),
`endif
    .wb_rd_reg_data_o (wb_rd_reg_data_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        is_load;
    logic [2:0]  f3;
    logic [1:0]  lsb;
    logic [31:0] raw;
    logic [31:0] reg_data;
    logic [4:0]  addr;
    logic        wr_en;
    logic [31:0] exp_data;
    logic        exp_wr_en;
  } vec_t;

  vec_t vecs[16];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] pc, input logic wr_en,
                               input logic [4:0] addr, input logic [31:0] reg_data,
                               input logic is_load, input logic [2:0] f3,
                               input logic [1:0] lsb, input logic [31:0] raw);
    wb_valid_i       = valid;
    wb_pc_i          = pc;
    wb_rd_wr_en_i    = wr_en;
    wb_rd_addr_i     = addr;
    wb_rd_reg_data_i = reg_data;
    wb_is_load_i     = is_load;
    wb_load_funct3_i = f3;
    wb_addr_lsb_i    = lsb;
    wb_load_data_i   = raw;
  endtask

  function automatic logic [31:0] alu_data(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic send_alu(input logic [31:0] pc);
    applyStimulus(1'b1, pc, 1'b1, 5'd3, alu_data(pc), 1'b0, 3'b000, 2'd0, 32'h0);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 3'b000, 2'd0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{"lb_lsb1",   1'b1, LB,   2'd1, 32'h80FF7F01, 32'h0, 5'd1, 1'b1, 32'h0000007F, 1'b1};
    vecs[1]  = '{"lb_lsb2",   1'b1, LB,   2'd2, 32'h80FF7F01, 32'h0, 5'd2, 1'b1, 32'hFFFFFFFF, 1'b1};
    vecs[2]  = '{"lhu_lsb2",  1'b1, LHU,  2'd2, 32'h80FF7F01, 32'h0, 5'd3, 1'b1, 32'h000080FF, 1'b1};
    vecs[3]  = '{"lh_lsb2",   1'b1, LH,   2'd2, 32'h80FF7F01, 32'h0, 5'd4, 1'b1, 32'hFFFF80FF, 1'b1};
    vecs[4]  = '{"lh_lsb3",   1'b1, LH,   2'd3, 32'h80FF7F01, 32'h0, 5'd5, 1'b1, 32'hFFFF80FF, 1'b1};
    vecs[5]  = '{"lbu_lsb3",  1'b1, LBU,  2'd3, 32'h80FF7F01, 32'h0, 5'd6, 1'b1, 32'h00000080, 1'b1};
    vecs[6]  = '{"lb_lsb3",   1'b1, LB,   2'd3, 32'h80FF7F01, 32'h0, 5'd7, 1'b1, 32'hFFFFFF80, 1'b1};
    vecs[7]  = '{"lw_lsb2",   1'b1, LW,   2'd2, 32'h80FF7F01, 32'h0, 5'd8, 1'b1, 32'h80FF7F01, 1'b1};
    vecs[8]  = '{"lwu_as_lw", 1'b1, LWU,  2'd0, 32'h80FF7F01, 32'h0, 5'd9, 1'b1, 32'h80FF7F01, 1'b1};
    vecs[9]  = '{"ld_as_lw",  1'b1, LD,   2'd1, 32'h80FF7F01, 32'h0, 5'd10, 1'b1, 32'h80FF7F01, 1'b1};
    vecs[10] = '{"lhu_lsb0",  1'b1, LHU,  2'd0, 32'h80FF7F01, 32'h0, 5'd11, 1'b1, 32'h00007F01, 1'b1};
    vecs[11] = '{"lh_lsb1",   1'b1, LH,   2'd1, 32'h80FF7F01, 32'h0, 5'd12, 1'b1, 32'h00007F01, 1'b1};
    vecs[12] = '{"raw_111",   1'b1, LRAW, 2'd3, 32'h80FF7F01, 32'h0, 5'd13, 1'b1, 32'h80FF7F01, 1'b1};
    vecs[13] = '{"alu_pass",  1'b0, LB,   2'd1, 32'h80FF7F01, 32'h12345678, 5'd14, 1'b1, 32'h12345678, 1'b1};
    vecs[14] = '{"x0_write",  1'b0, LB,   2'd0, 32'h0, 32'hDEADBEEF, 5'd0, 1'b1, 32'hDEADBEEF, 1'b0};
    vecs[15] = '{"no_wr_en",  1'b1, LBU,  2'd0, 32'h80FF7F01, 32'h0, 5'd15, 1'b0, 32'h00000001, 1'b0};

    // Reset: everything low while rst_n is held.
    idle();
    #12;
    checkOutput("rst_valid", {63'd0, wb_valid_o}, 64'd0);
    checkOutput("rst_ready", {63'd0, wb_ready_o}, 64'd0);
    checkOutput("rst_pc", {32'd0, wb_pc_o}, 64'd0);
    checkOutput("rst_wr_en", {63'd0, wb_rd_wr_en_o}, 64'd0);
    checkOutput("rst_addr", {59'd0, wb_rd_addr_o}, 64'd0);
    checkOutput("rst_data", {32'd0, wb_rd_reg_data_o}, 64'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("post_rst_ready", {63'd0, wb_ready_o}, 64'd1);

    // Table-driven load alignment and x0 suppression.
    wb_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 32'h1000 + 32'(i * 4), vecs[i].wr_en, vecs[i].addr, vecs[i].reg_data,
                    vecs[i].is_load, vecs[i].f3, vecs[i].lsb, vecs[i].raw);
      tick();
      idle();
      checkOutput({vecs[i].name, "_valid"}, {63'd0, wb_valid_o}, 64'd1);
      checkOutput({vecs[i].name, "_data"}, {32'd0, wb_rd_reg_data_o}, {32'd0, vecs[i].exp_data});
      checkOutput({vecs[i].name, "_wr_en"}, {63'd0, wb_rd_wr_en_o}, {63'd0, vecs[i].exp_wr_en});
      checkOutput({vecs[i].name, "_addr"}, {59'd0, wb_rd_addr_o}, {59'd0, vecs[i].addr});
      checkOutput({vecs[i].name, "_pc"}, {32'd0, wb_pc_o}, {32'd0, 32'h1000 + 32'(i * 4)});
    end
    tick();
    checkOutput("table_drain_valid", {63'd0, wb_valid_o}, 64'd0);

    // Streaming: eight back-to-back instructions, one output per cycle.
    for (int k = 0; k < 8; k++) begin
      checkOutput("stream_ready", {63'd0, wb_ready_o}, 64'd1);
      send_alu(32'h2000 + 32'(k * 4));
      tick();
      checkOutput("stream_valid", {63'd0, wb_valid_o}, 64'd1);
      checkOutput("stream_pc", {32'd0, wb_pc_o}, {32'd0, 32'h2000 + 32'(k * 4)});
    end
    idle();
    tick();
    checkOutput("stream_end_valid", {63'd0, wb_valid_o}, 64'd0);

    // Back-pressure: third input refused, outputs stable, skid drains in order.
    wb_ready_i = 1'b0;
    send_alu(32'h3000);
    tick();
    checkOutput("bp_a_valid", {63'd0, wb_valid_o}, 64'd1);
    checkOutput("bp_a_ready", {63'd0, wb_ready_o}, 64'd1);
    send_alu(32'h3004);
    tick();
    checkOutput("bp_b_ready", {63'd0, wb_ready_o}, 64'd0);
    checkOutput("bp_b_pc", {32'd0, wb_pc_o}, {32'd0, 32'h3000});
    send_alu(32'h3008);
    tick();
    checkOutput("bp_c_ready", {63'd0, wb_ready_o}, 64'd0);
    checkOutput("bp_hold_pc", {32'd0, wb_pc_o}, {32'd0, 32'h3000});
    checkOutput("bp_hold_data", {32'd0, wb_rd_reg_data_o}, {32'd0, alu_data(32'h3000)});
    idle();
    wb_ready_i = 1'b1;
    tick();
    checkOutput("bp_drain_pc", {32'd0, wb_pc_o}, {32'd0, 32'h3004});
    checkOutput("bp_drain_valid", {63'd0, wb_valid_o}, 64'd1);
    checkOutput("bp_drain_ready", {63'd0, wb_ready_o}, 64'd1);
    tick();
    checkOutput("bp_empty_valid", {63'd0, wb_valid_o}, 64'd0);

    // Flush with a full buffer and a simultaneous input.
    wb_ready_i = 1'b0;
    send_alu(32'h4000);
    tick();
    send_alu(32'h4004);
    tick();
    checkOutput("fl_full_ready", {63'd0, wb_ready_o}, 64'd0);
    send_alu(32'h4008);
    wb_flush_i = 1'b1;
    tick();
    wb_flush_i = 1'b0;
    idle();
    checkOutput("fl_valid", {63'd0, wb_valid_o}, 64'd0);
    checkOutput("fl_ready", {63'd0, wb_ready_o}, 64'd1);
    wb_ready_i = 1'b1;
    tick();
    checkOutput("fl_after_valid", {63'd0, wb_valid_o}, 64'd0);
    // Flush while the stage is ready: the input must still be dropped.
    send_alu(32'h400C);
    wb_flush_i = 1'b1;
    tick();
    wb_flush_i = 1'b0;
    idle();
    checkOutput("fl_in_dropped", {63'd0, wb_valid_o}, 64'd0);
    tick();
    checkOutput("fl_in_never", {63'd0, wb_valid_o}, 64'd0);

    // Asynchronous reset mid-operation clears the stage before the next edge.
    wb_ready_i = 1'b0;
    send_alu(32'h5000);
    tick();
    idle();
    checkOutput("ar_pre_valid", {63'd0, wb_valid_o}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("ar_valid", {63'd0, wb_valid_o}, 64'd0);
    checkOutput("ar_pc", {32'd0, wb_pc_o}, 64'd0);
    checkOutput("ar_ready", {63'd0, wb_ready_o}, 64'd0);
    #2 rst_n = 1'b1;
    tick();
    checkOutput("ar_post_ready", {63'd0, wb_ready_o}, 64'd1);
    checkOutput("ar_post_valid", {63'd0, wb_valid_o}, 64'd0);

`ifdef WB_RETIRE_CNT_EN
    // Retire counter: 3 streamed + 2 stalled handshakes, flushed entry not counted.
    checkOutput("cnt_start", wb_instret_o, 64'd0);
    wb_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send_alu(32'h6000 + 32'(k * 4));
      tick();
    end
    idle();
    tick();
    wb_ready_i = 1'b0;
    send_alu(32'h600C);
    tick();
    send_alu(32'h6010);
    tick();
    idle();
    tick();
    tick();
    wb_ready_i = 1'b1;
    tick();
    tick();
    wb_ready_i = 1'b0;
    send_alu(32'h6014);
    tick();
    idle();
    wb_flush_i = 1'b1;
    tick();
    wb_flush_i = 1'b0;
    checkOutput("cnt_flush_valid", {63'd0, wb_valid_o}, 64'd0);
    checkOutput("cnt_five", wb_instret_o, 64'd5);
    wb_ready_i = 1'b1;
    send_alu(32'h6018);
    tick();
    idle();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("cnt_async_clear", wb_instret_o, 64'd0);
    #2 rst_n = 1'b1;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
